// File: rtl/sap_pkg.sv
// Shared SAP definitions: opcodes, RAM sequencer states and the default boot image.
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ram_state_t;

    localparam int unsigned BOOT_LEN = 10;

    // Default program: LDA 6, ADD 7, ADD 8, SUB 9, OUT, HLT, then data 1, 3, 2, 3
    localparam logic [7:0] BOOT_IMG [BOOT_LEN] = '{
        {OP_LDA, 4'h6},
        {OP_ADD, 4'h7},
        {OP_ADD, 4'h8},
        {OP_SUB, 4'h9},
        {OP_OUT, 4'h0},
        {OP_HLT, 4'h0},
        8'h01,
        8'h03,
        8'h02,
        8'h03
    };

    // Boot word lookup; indices past the image read as 0
    function automatic logic [7:0] boot_word(input int unsigned idx);
        logic [7:0] w;
        w = 8'h00;
        case (idx)
            0:       w = BOOT_IMG[0];
            1:       w = BOOT_IMG[1];
            2:       w = BOOT_IMG[2];
            3:       w = BOOT_IMG[3];
            4:       w = BOOT_IMG[4];
            5:       w = BOOT_IMG[5];
            6:       w = BOOT_IMG[6];
            7:       w = BOOT_IMG[7];
            8:       w = BOOT_IMG[8];
            9:       w = BOOT_IMG[9];
            default: w = 8'h00;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sap_ram_core.sv
// Plain 1R1W storage array: synchronous write, synchronous read-before-write.
module sap_ram_core #(
    parameter int unsigned MEM_W  = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [MEM_W-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [MEM_W-1:0]  o_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [MEM_W-1:0] r_mem [DEPTH];
    logic [MEM_W-1:0] r_rdata;

    // Array write; contents are rebuilt by the init sequencer so no reset here
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read, holds its value when no read is requested; sees the old word on a same-address write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sap_ram_sync.sv
// SAP program/data RAM: boot-image init sequencer, registered read, tri-state W bus.
// Optional build macro MEM_PARITY_EN adds a stored even-parity bit and a sticky par_err flag.
module sap_ram_sync
    import sap_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned IMG_LEN = 10
) (
    input  logic              CLK,
    input  logic              CLR_barra,
    input  logic              CE_barra,
    input  logic              WE_barra,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] D,
    output wire  [DATA_W-1:0] W,
    output logic              ready,
    output logic              par_err
);

`ifdef MEM_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned       MEM_W     = DATA_W + PAR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    ram_state_t        r_state;
    ram_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_init_ptr;
    logic              r_oe;

    logic              w_mem_we;
    logic              w_mem_re;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_data_in;
    logic [DATA_W-1:0] w_boot_word;
    logic [MEM_W-1:0]  w_wdata;
    logic [MEM_W-1:0]  w_rd_word;

    // State register; reset always restarts the init sequence
    always_ff @(posedge CLK or negedge CLR_barra) begin
        if (!CLR_barra) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave INIT after writing the last address, stay in RUN until reset
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == INIT && r_init_ptr == LAST_ADDR) begin
            w_state_nxt = RUN;
        end
    end

    // Memory port steering: INIT owns the write port, RUN hands both ports to the bus
    always_comb begin
        w_mem_we  = 1'b0;
        w_mem_re  = 1'b0;
        w_waddr   = address;
        w_data_in = D;
        case (r_state)
            INIT: begin
                w_mem_we  = 1'b1;
                w_waddr   = r_init_ptr;
                w_data_in = w_boot_word;
            end
            RUN: begin
                w_mem_we = !WE_barra;
                w_mem_re = !CE_barra;
            end
            default: begin
                w_mem_we = 1'b0;
            end
        endcase
    end

    // Boot word for the current init pointer; zero beyond the image
    always_comb begin
        w_boot_word = '0;
        if (32'(r_init_ptr) < IMG_LEN) begin
            w_boot_word = DATA_W'(boot_word(32'(r_init_ptr)));
        end
    end

    // Stored word, with an even-parity bit on top when parity is built in
    always_comb begin
`ifdef MEM_PARITY_EN
        w_wdata = {^w_data_in, w_data_in};
`else
        w_wdata = w_data_in;
`endif
    end

    // Init pointer walks every address once per init pass
    always_ff @(posedge CLK or negedge CLR_barra) begin
        if (!CLR_barra) begin
            r_init_ptr <= '0;
        end else if (r_state == INIT) begin
            r_init_ptr <= r_init_ptr + ADDR_W'(1);
        end
    end

    // Bus drive enable follows the read request one cycle later
    always_ff @(posedge CLK or negedge CLR_barra) begin
        if (!CLR_barra) begin
            r_oe <= 1'b0;
        end else begin
            r_oe <= w_mem_re;
        end
    end

    sap_ram_core #(
        .MEM_W  (MEM_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk     (CLK),
        .rst_n   (CLR_barra),
        .i_we    (w_mem_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_mem_re),
        .i_raddr (address),
        .o_rdata (w_rd_word)
    );

    assign W     = r_oe ? w_rd_word[DATA_W-1:0] : 'z;
    assign ready = (r_state == RUN);

`ifdef MEM_PARITY_EN
    logic r_par_err;

    // Sticky parity flag: recheck each freshly read word while it is on the bus
    always_ff @(posedge CLK or negedge CLR_barra) begin
        if (!CLR_barra) begin
            r_par_err <= 1'b0;
        end else if (r_oe && (^w_rd_word)) begin
            r_par_err <= 1'b1;
        end
    end

    assign par_err = r_par_err;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sap_ram_sync.sv
// Directed bench for sap_ram_sync: init timing, boot image, bus timing, writes, read-before-write, resets, parity.
module tb_sap_ram_sync;

    logic       CLK;
    logic       CLR_barra;
    logic       CE_barra;
    logic       WE_barra;
    logic [3:0] address;
    logic [7:0] D;
    wire  [7:0] W;
    logic       ready;
    logic       par_err;

    int unsigned n_checks;
    int unsigned n_pass;
    logic [7:0]  exp_img [16];

    sap_ram_sync dut (
        .CLK       (CLK),
        .CLR_barra (CLR_barra),
        .CE_barra  (CE_barra),
        .WE_barra  (WE_barra),
        .address   (address),
        .D         (D),
        .W         (W),
        .ready     (ready),
        .par_err   (par_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Full init: ready must stay low for 15 edges and rise on the 16th
    task automatic run_init(input string tag);
        tick(15);
        check({tag, "_ready_lo"}, 32'(ready), 32'd0);
        tick(1);
        check({tag, "_ready_hi"}, 32'(ready), 32'd1);
    endtask

    task automatic read_word(input logic [3:0] a, input logic [7:0] exp, input string tag);
        CE_barra = 1'b0;
        address  = a;
        tick(1);
        check(tag, 32'(W), 32'(exp));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_img  = '{8'h06, 8'h17, 8'h18, 8'h29, 8'hE0, 8'hF0, 8'h01, 8'h03,
                     8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        CLR_barra = 1'b0;
        CE_barra  = 1'b1;
        WE_barra  = 1'b1;
        address   = 4'h0;
        D         = 8'h00;
        tick(2);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_par", 32'(par_err), 32'd0);
        check("rst_oe", 32'(dut.r_oe), 32'd0);

        CLR_barra = 1'b1;
        run_init("init0");

        for (int i = 0; i < 16; i++) begin
            read_word(4'(i), exp_img[i], $sformatf("boot_rd%0d", i));
        end

        // Bus release one edge after CE_barra rises
        CE_barra = 1'b1;
        check("oe_before_rise_edge", 32'(dut.r_oe), 32'd1);
        tick(1);
        check("oe_released", 32'(dut.r_oe), 32'd0);
        address = 4'h1;
        CE_barra = 1'b0;
        check("oe_before_fall_edge", 32'(dut.r_oe), 32'd0);
        tick(1);
        check("oe_driven", 32'(dut.r_oe), 32'd1);
        check("w_addr1", 32'(W), 32'h17);
        CE_barra = 1'b1;
        tick(1);

        // Plain write then read-back, neighbour untouched
        WE_barra = 1'b0;
        address  = 4'h3;
        D        = 8'hA5;
        tick(1);
        WE_barra = 1'b1;
        read_word(4'h3, 8'hA5, "wr_rd3");
        read_word(4'h2, 8'h18, "nbr_rd2");
        CE_barra = 1'b1;
        tick(1);

        // Same-address read and write: old word on the bus, new word stored
        CE_barra = 1'b0;
        WE_barra = 1'b0;
        address  = 4'h5;
        D        = 8'h3C;
        tick(1);
        check("rbw_old", 32'(W), 32'hF0);
        WE_barra = 1'b1;
        tick(1);
        check("rbw_new", 32'(W), 32'h3C);
        CE_barra = 1'b1;
        tick(1);

        // Reset in RUN, then reset again during INIT at pointer 7 with bus requests held
        CLR_barra = 1'b0;
        #1;
        CLR_barra = 1'b1;
        CE_barra  = 1'b0;
        WE_barra  = 1'b0;
        address   = 4'h0;
        D         = 8'hFF;
        tick(7);
        check("init_ptr7_ready", 32'(ready), 32'd0);
        check("init_ce_ignored", 32'(dut.r_oe), 32'd0);
        CLR_barra = 1'b0;
        #1;
        check("init_abort_ready", 32'(ready), 32'd0);
        CE_barra  = 1'b1;
        WE_barra  = 1'b1;
        CLR_barra = 1'b1;
        run_init("init1");
        read_word(4'h0, 8'h06, "after_init1_rd0");

        WE_barra = 1'b0;
        CE_barra = 1'b1;
        address  = 4'h4;
        D        = 8'h55;
        tick(1);
        WE_barra = 1'b1;
        read_word(4'h4, 8'h55, "wr_rd4");

        // Asynchronous reset while driving the bus
        CLR_barra = 1'b0;
        #1;
        check("run_rst_oe", 32'(dut.r_oe), 32'd0);
        check("run_rst_ready", 32'(ready), 32'd0);
        CE_barra  = 1'b1;
        CLR_barra = 1'b1;
        run_init("init2");
        read_word(4'h4, 8'hE0, "restore_rd4");
        read_word(4'h3, 8'h29, "restore_rd3");
        read_word(4'h5, 8'hF0, "restore_rd5");
        CE_barra = 1'b1;
        tick(1);

`ifdef MEM_PARITY_EN
        dut.u_core.r_mem[6][0] = ~dut.u_core.r_mem[6][0];
        read_word(4'h6, 8'h00, "par_flip_data");
        tick(1);
        check("par_err_set", 32'(par_err), 32'd1);
        CE_barra = 1'b1;
        tick(2);
        check("par_err_sticky", 32'(par_err), 32'd1);
        CLR_barra = 1'b0;
        #1;
        check("par_err_rst", 32'(par_err), 32'd0);
        CLR_barra = 1'b1;
        run_init("init3");
        read_word(4'h6, 8'h01, "par_restored");
        tick(1);
        check("par_err_clean", 32'(par_err), 32'd0);
`else
        check("par_err_tied", 32'(par_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
